// File: rtl/quat_rot_integrator.sv
// Per-frame quaternion rotation integrator: rot[i] <= angvel[i] * rot[i] for every model,
// evaluated term by term on one shared fixed-point multiplier-accumulator.
module quat_rot_integrator #(
  parameter int N_MODELS     = 4,
  parameter int W            = 16,
  parameter bit AUTO_FRAME   = 1'b1,
  parameter int FRAME_CYCLES = 1000,
  parameter int FC_W         = 16,
  localparam int IW          = (N_MODELS > 1) ? $clog2(N_MODELS) : 1
) (
  input  logic            sysclk,
  input  logic            reset,
  input  logic            cfg_we,
  input  logic            cfg_sel,
  input  logic [IW-1:0]   cfg_idx,
  input  logic [4*W-1:0]  cfg_data,
  input  logic            start,
  input  logic [IW-1:0]   rd_idx,
  output logic [4*W-1:0]  rd_rot,
  output logic            busy,
  output logic            update,
  output logic [FC_W-1:0] frame_count,
  output logic            sat_flag,
  output logic            overrun,
  output logic            cfg_err
);

  localparam int AW = 2*W + 2;
  localparam int TW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [4*W-1:0]       IDENT = {W'(2**(W-2)), {(3*W){1'b0}}};
  localparam logic signed [AW-1:0] MAX_V = AW'((2**(W-1)) - 1);
  localparam logic signed [AW-1:0] MIN_V = AW'(-(2**(W-1)));
  localparam logic signed [AW-1:0] HALF  = AW'(2**(W-3));

  typedef enum logic [2:0] {IDLE, LOAD, MAC, WRITE, DONE} state_t;

  state_t state_q, state_d;

  logic [4*W-1:0]         rot_q    [N_MODELS];
  logic [4*W-1:0]         angvel_q [N_MODELS];
  logic signed [W-1:0]    a_q   [4];
  logic signed [W-1:0]    b_q   [4];
  logic signed [W-1:0]    res_q [4];
  logic signed [AW-1:0]   acc_q;
  logic [3:0]             k_q;
  logic [IW-1:0]          idx_q;
  logic [TW-1:0]          timer_q;
  logic [FC_W-1:0]        frame_count_q;
  logic                   sat_q, overrun_q, cfg_err_q;

  logic                   tick, tick_ok, last_model, cfg_idx_ok;
  logic [1:0]             t, c, q;
  logic                   neg;
  logic signed [2*W-1:0]  prod;
  logic signed [AW-1:0]   prod_ext, term, sum, rnd, shifted;
  logic                   clamp_hi, clamp_lo;
  logic signed [W-1:0]    comp_val;

  function automatic logic signed [W-1:0] get_comp(input logic [4*W-1:0] qv, input int p);
    return qv[(3-p)*W +: W];
  endfunction

  assign tick       = AUTO_FRAME ? (timer_q == TW'(FRAME_CYCLES-1)) : start;
  assign tick_ok    = tick && ((state_q == IDLE) || (state_q == DONE));
  assign last_model = (idx_q == IW'(N_MODELS-1));
  assign cfg_idx_ok = (int'(cfg_idx) < N_MODELS);

  assign rd_rot      = (int'(rd_idx) < N_MODELS) ? rot_q[rd_idx] : '0;
  assign frame_count = frame_count_q;
  assign sat_flag    = sat_q;
  assign overrun     = overrun_q;
  assign cfg_err     = cfg_err_q;

  // Term t of component c pairs a[t] with b[t^c]; only the sign pattern needs a table.
  assign t = k_q[1:0];
  assign c = k_q[3:2];
  assign q = t ^ c;

  always_comb begin
    neg = 1'b0;
    case ({c, t})
      4'b00_01, 4'b00_10, 4'b00_11: neg = 1'b1;
      4'b01_11:                     neg = 1'b1;
      4'b10_01:                     neg = 1'b1;
      4'b11_10:                     neg = 1'b1;
      default:                      neg = 1'b0;
    endcase
  end

  assign prod     = a_q[t] * b_q[q];
  assign prod_ext = {{2{prod[2*W-1]}}, prod};
  assign term     = neg ? -prod_ext : prod_ext;
  assign sum      = (t == 2'd0) ? term : acc_q + term;
  assign rnd      = sum + HALF;
  assign shifted  = rnd >>> (W-2);
  assign clamp_hi = (shifted > MAX_V);
  assign clamp_lo = (shifted < MIN_V);

  always_comb begin
    comp_val = shifted[W-1:0];
    if (clamp_hi)      comp_val = MAX_V[W-1:0];
    else if (clamp_lo) comp_val = MIN_V[W-1:0];
  end

  always_ff @(posedge sysclk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    update  = 1'b0;
    case (state_q)
      IDLE: if (tick) state_d = LOAD;
      LOAD: begin
        busy    = 1'b1;
        state_d = MAC;
      end
      MAC: begin
        busy = 1'b1;
        if (k_q == 4'd15) state_d = WRITE;
      end
      WRITE: begin
        busy    = 1'b1;
        state_d = last_model ? DONE : LOAD;
      end
      DONE: begin
        update  = 1'b1;
        state_d = tick ? LOAD : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A config write and an accepted tick may share a cycle; the write lands before LOAD reads.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      for (int m = 0; m < N_MODELS; m++) begin
        rot_q[m]    <= IDENT;
        angvel_q[m] <= IDENT;
      end
      for (int p = 0; p < 4; p++) begin
        a_q[p]   <= '0;
        b_q[p]   <= '0;
        res_q[p] <= '0;
      end
      acc_q         <= '0;
      k_q           <= '0;
      idx_q         <= '0;
      timer_q       <= '0;
      frame_count_q <= '0;
      sat_q         <= 1'b0;
      overrun_q     <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      timer_q <= (timer_q == TW'(FRAME_CYCLES-1)) ? '0 : timer_q + TW'(1);

      if (tick && busy) overrun_q <= 1'b1;

      if (cfg_we) begin
        if (busy) begin
          cfg_err_q <= 1'b1;
        end else if (cfg_idx_ok) begin
          if (cfg_sel) angvel_q[cfg_idx] <= cfg_data;
          else         rot_q[cfg_idx]    <= cfg_data;
        end
      end

      case (state_q)
        IDLE: if (tick_ok) idx_q <= '0;
        LOAD: begin
          for (int p = 0; p < 4; p++) begin
            a_q[p] <= get_comp(angvel_q[idx_q], p);
            b_q[p] <= get_comp(rot_q[idx_q], p);
          end
          k_q <= '0;
        end
        MAC: begin
          acc_q <= sum;
          k_q   <= k_q + 4'd1;
          if (t == 2'd3) begin
            res_q[c] <= comp_val;
            if (clamp_hi || clamp_lo) sat_q <= 1'b1;
          end
        end
        WRITE: begin
          rot_q[idx_q] <= {res_q[0], res_q[1], res_q[2], res_q[3]};
          if (!last_model) idx_q <= idx_q + IW'(1);
        end
        DONE: begin
          frame_count_q <= frame_count_q + FC_W'(1);
          if (tick_ok) idx_q <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_quat_rot_integrator.sv
// Self-checking bench for quat_rot_integrator: constant vectors, directed corner sequences,
// and random frames compared against a formula-level quaternion product model.
module tb_quat_rot_integrator;

  typedef logic [63:0] quat_t;

  typedef struct {
    logic       wr;
    logic [1:0] idx;
    quat_t      ang;
    quat_t      rot;
    quat_t      exp_rot;
    logic       exp_sat;
  } vec_t;

  logic        sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // Externally started instance
  logic        reset = 1'b1;
  logic        cfg_we = 1'b0, cfg_sel = 1'b0, start = 1'b0;
  logic [1:0]  cfg_idx = '0, rd_idx = '0;
  quat_t       cfg_data = '0;
  quat_t       rd_rot;
  logic        busy, update, sat_flag, overrun, cfg_err;
  logic [15:0] frame_count;

  // Auto-timed instance with a narrow frame counter
  logic        a_reset = 1'b1;
  logic        a_cfg_we = 1'b0, a_cfg_sel = 1'b0, a_start = 1'b0;
  logic [1:0]  a_cfg_idx = '0, a_rd_idx = '0;
  quat_t       a_cfg_data = '0;
  quat_t       a_rd_rot;
  logic        a_busy, a_update, a_sat_flag, a_overrun, a_cfg_err;
  logic [3:0]  a_frame_count;

  quat_rot_integrator #(.N_MODELS(4), .W(16), .AUTO_FRAME(1'b0), .FRAME_CYCLES(1000), .FC_W(16)) dut (
    .sysclk(sysclk), .reset(reset), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_idx(cfg_idx),
    .cfg_data(cfg_data), .start(start), .rd_idx(rd_idx), .rd_rot(rd_rot), .busy(busy),
    .update(update), .frame_count(frame_count), .sat_flag(sat_flag), .overrun(overrun),
    .cfg_err(cfg_err)
  );

  quat_rot_integrator #(.N_MODELS(4), .W(16), .AUTO_FRAME(1'b1), .FRAME_CYCLES(100), .FC_W(4)) dut_auto (
    .sysclk(sysclk), .reset(a_reset), .cfg_we(a_cfg_we), .cfg_sel(a_cfg_sel), .cfg_idx(a_cfg_idx),
    .cfg_data(a_cfg_data), .start(a_start), .rd_idx(a_rd_idx), .rd_rot(a_rd_rot), .busy(a_busy),
    .update(a_update), .frame_count(a_frame_count), .sat_flag(a_sat_flag), .overrun(a_overrun),
    .cfg_err(a_cfg_err)
  );

  int errors = 0;
  int checks = 0;

  quat_t m_rot[4];
  quat_t m_ang[4];
  logic  m_sat;
  int    m_fc;

  function automatic quat_t mkq(input int w, input int x, input int y, input int z);
    return {16'(w), 16'(x), 16'(y), 16'(z)};
  endfunction

  function automatic longint qc(input quat_t qv, input int p);
    logic signed [15:0] v;
    v = qv[(3-p)*16 +: 16];
    return longint'(v);
  endfunction

  // Hamilton product from the textbook formula, rounded half-up and clamped to Q2.14
  function automatic quat_t qmul(input quat_t a, input quat_t b, output logic sat);
    longint s[4];
    longint r;
    quat_t  res;
    sat  = 1'b0;
    s[0] = qc(a,0)*qc(b,0) - qc(a,1)*qc(b,1) - qc(a,2)*qc(b,2) - qc(a,3)*qc(b,3);
    s[1] = qc(a,0)*qc(b,1) + qc(a,1)*qc(b,0) + qc(a,2)*qc(b,3) - qc(a,3)*qc(b,2);
    s[2] = qc(a,0)*qc(b,2) - qc(a,1)*qc(b,3) + qc(a,2)*qc(b,0) + qc(a,3)*qc(b,1);
    s[3] = qc(a,0)*qc(b,3) + qc(a,1)*qc(b,2) - qc(a,2)*qc(b,1) + qc(a,3)*qc(b,0);
    res = '0;
    for (int p = 0; p < 4; p++) begin
      r = (s[p] + 64'sd8192) >>> 14;
      if (r > 32767)       begin r = 32767;  sat = 1'b1; end
      else if (r < -32768) begin r = -32768; sat = 1'b1; end
      res[(3-p)*16 +: 16] = 16'(r);
    end
    return res;
  endfunction

  function automatic quat_t rand_q();
    quat_t qv;
    for (int p = 0; p < 4; p++)
      if ($urandom_range(0, 1) == 1) qv[p*16 +: 16] = 16'($urandom_range(0, 32768) - 16384);
      else                           qv[p*16 +: 16] = 16'($urandom);
    return qv;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_rot[i] = mkq(16384, 0, 0, 0);
      m_ang[i] = mkq(16384, 0, 0, 0);
    end
    m_sat = 1'b0;
    m_fc  = 0;
  endtask

  task automatic model_frame();
    logic s;
    for (int i = 0; i < 4; i++) begin
      m_rot[i] = qmul(m_ang[i], m_rot[i], s);
      m_sat    = m_sat | s;
    end
    m_fc++;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic sel, input logic [1:0] idx, input quat_t data);
    cfg_we   = 1'b1;
    cfg_sel  = sel;
    cfg_idx  = idx;
    cfg_data = data;
    cyc(1);
    cfg_we   = 1'b0;
    if (sel) m_ang[idx] = data;
    else     m_rot[idx] = data;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    cfg_we = 1'b0;
    start  = 1'b0;
    cyc(2);
    reset  = 1'b0;
    model_reset();
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 4; i++) begin
      rd_idx = 2'(i);
      #1;
      checkOutput($sformatf("%s rot[%0d]", tag, i), rd_rot, m_rot[i]);
    end
    checkOutput({tag, " frame_count"}, 64'(frame_count), 64'(m_fc));
    checkOutput({tag, " sat_flag"}, 64'(sat_flag), 64'(m_sat));
  endtask

  // Pulses start (any pending cfg_we rides along in the same cycle) and times the frame.
  task automatic run_frame(input string tag);
    int n;
    int busy_cnt;
    start = 1'b1;
    cyc(1);
    start  = 1'b0;
    cfg_we = 1'b0;
    n = 1;
    busy_cnt = 0;
    while (!update && n < 300) begin
      if (busy) busy_cnt++;
      cyc(1);
      n++;
    end
    if (!update) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout: got no update after %0d cycles, want 73", tag, n);
    end else begin
      checkOutput({tag, " latency"}, 64'(n), 64'd73);
      checkOutput({tag, " busy cycles"}, 64'(busy_cnt), 64'd72);
      checkOutput({tag, " busy in done"}, 64'(busy), 64'd0);
    end
    model_frame();
    cyc(1);
    checkOutput({tag, " update width"}, 64'(update), 64'd0);
  endtask

  vec_t vecs[6];

  initial begin
    int upd_cnt;
    int next_exp;

    vecs[0] = '{1'b1, 2'd0, mkq(16384,0,0,0),     mkq(16384,0,0,0),      mkq(16384,0,0,0),      1'b0};
    vecs[1] = '{1'b1, 2'd0, mkq(11585,11585,0,0), mkq(16384,0,0,0),      mkq(11585,11585,0,0),  1'b0};
    vecs[2] = '{1'b0, 2'd0, '0,                   '0,                    mkq(0,16383,0,0),      1'b0};
    vecs[3] = '{1'b1, 2'd1, mkq(0,0,16384,0),     mkq(0,16384,0,0),      mkq(0,0,0,-16384),     1'b0};
    vecs[4] = '{1'b1, 2'd3, mkq(1,0,0,0),         mkq(8192,-8192,8191,-8193), mkq(1,0,0,-1),    1'b0};
    vecs[5] = '{1'b1, 2'd2, mkq(32767,0,0,0),     mkq(32767,0,0,0),      mkq(32767,0,0,0),      1'b1};

    cyc(1);
    do_reset();
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset update", 64'(update), 64'd0);
    checkOutput("reset overrun", 64'(overrun), 64'd0);
    checkOutput("reset cfg_err", 64'(cfg_err), 64'd0);
    check_all("reset");

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].wr) begin
        applyStimulus(1'b1, vecs[v].idx, vecs[v].ang);
        applyStimulus(1'b0, vecs[v].idx, vecs[v].rot);
      end
      run_frame($sformatf("vec%0d", v));
      rd_idx = vecs[v].idx;
      #1;
      checkOutput($sformatf("vec%0d result", v), rd_rot, vecs[v].exp_rot);
      checkOutput($sformatf("vec%0d sat", v), 64'(sat_flag), 64'(vecs[v].exp_sat));
      check_all($sformatf("vec%0d", v));
    end

    run_frame("sat sticky");
    checkOutput("sat sticky flag", 64'(sat_flag), 64'd1);
    check_all("sat sticky");

    // Overrun and dropped config write
    do_reset();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(9);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(9);
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_idx = 2'd1; cfg_data = mkq(1, 2, 3, 4);
    cyc(1);
    cfg_we = 1'b0;
    upd_cnt = 0;
    for (int n = 0; n < 150; n++) begin
      if (update) upd_cnt++;
      cyc(1);
    end
    model_frame();
    checkOutput("overrun update count", 64'(upd_cnt), 64'd1);
    checkOutput("overrun flag", 64'(overrun), 64'd1);
    checkOutput("cfg_err flag", 64'(cfg_err), 64'd1);
    rd_idx = 2'd1;
    #1;
    checkOutput("dropped write target", rd_rot, mkq(16384, 0, 0, 0));
    check_all("overrun");

    // Config write in the same cycle as the accepted start
    cfg_we = 1'b1; cfg_sel = 1'b1; cfg_idx = 2'd0; cfg_data = mkq(11585, 11585, 0, 0);
    m_ang[0] = mkq(11585, 11585, 0, 0);
    run_frame("same-cycle cfg");
    rd_idx = 2'd0;
    #1;
    checkOutput("same-cycle cfg result", rd_rot, mkq(11585, 11585, 0, 0));
    check_all("same-cycle cfg");

    // Reset mid-frame, after models 0 and 1 were already written back
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(39);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    model_reset();
    checkOutput("midreset busy", 64'(busy), 64'd0);
    checkOutput("midreset overrun", 64'(overrun), 64'd0);
    checkOutput("midreset cfg_err", 64'(cfg_err), 64'd0);
    check_all("midreset");
    upd_cnt = 0;
    for (int n = 0; n < 100; n++) begin
      if (update) upd_cnt++;
      cyc(1);
    end
    checkOutput("midreset no update", 64'(upd_cnt), 64'd0);

    for (int r = 0; r < 8; r++) begin
      int nw;
      nw = $urandom_range(1, 3);
      for (int w = 0; w < nw; w++)
        applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), rand_q());
      run_frame($sformatf("rand%0d", r));
      check_all($sformatf("rand%0d", r));
    end

    // Auto-timed instance: first pulse at cycle 172, then every 100 cycles, counter wraps at 16
    a_reset = 1'b0;
    upd_cnt  = 0;
    next_exp = 172;
    for (int n = 1; n <= 1800; n++) begin
      cyc(1);
      if (a_update) begin
        checkOutput($sformatf("auto pulse%0d cycle", upd_cnt), 64'(n), 64'(next_exp));
        checkOutput($sformatf("auto pulse%0d frame_count", upd_cnt), 64'(a_frame_count), 64'(upd_cnt % 16));
        upd_cnt++;
        next_exp = n + 100;
      end
    end
    checkOutput("auto pulse count", 64'(upd_cnt), 64'd17);
    checkOutput("auto wrapped count", 64'(a_frame_count), 64'd1);
    a_rd_idx = 2'd3;
    #1;
    checkOutput("auto identity rot", a_rd_rot, mkq(16384, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
